// File: rtl/profiler_pkg.sv
// profiler_pkg: types and widths shared by the event counter bank and the
// cache profilers that sit beside the core.
//   cnt_mode_t  : per-channel counting mode (LEVEL / EDGE)
//   PROF_*      : shared width defaults
//   prof_aw()   : address width for a bank of n channels (never below 1)
package profiler_pkg;

  typedef enum logic {CNT_LEVEL = 1'b0, CNT_EDGE = 1'b1} cnt_mode_t;

  localparam int PROF_CNT_W  = 32;
  localparam int PROF_MAX_CH = 32;

  function automatic int prof_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_counter_bank_if.sv
// event_counter_bank_if: snapshot handshake and shadow-bank read port.
//   snap_req  : capture all live counters into the shadow bank
//   snap_done : one-cycle pulse the cycle after a capture
//   rd_en/rd_addr            : read request and channel index
//   rd_valid/rd_data/rd_ovf  : registered read response, one-cycle pulse
// master = software side, slave = event_counter_bank.
interface event_counter_bank_if
  import profiler_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = PROF_CNT_W,
  parameter int AW     = prof_aw(NUM_CH)
);
  logic             snap_req;
  logic             snap_done;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             rd_ovf;

  modport master (
    output snap_req, rd_en, rd_addr,
    input  snap_done, rd_valid, rd_data, rd_ovf
  );

  modport slave (
    input  snap_req, rd_en, rd_addr,
    output snap_done, rd_valid, rd_data, rd_ovf
  );
endinterface

// File: rtl/event_counter_channel.sv
// event_counter_channel: one profiler channel.
//   ev/mode/enable : raw event, counting mode, global count enable
//   clear          : synchronous clear of cnt and ovf (wins over counting)
//   snap           : copy pre-edge cnt/ovf into the shadow pair
//   cnt/ovf        : live counter and sticky overflow flag
//   shadow_cnt/ovf : snapshot copy read by software
module event_counter_channel
  import profiler_pkg::*;
#(
  parameter int CNT_W    = PROF_CNT_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             ev,
  input  cnt_mode_t        mode,
  input  logic             snap,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic [CNT_W-1:0] shadow_cnt,
  output logic             shadow_ovf
);

  logic ev_q;
  logic inc;
  logic at_max;

  // ev_q tracks the input even while disabled, so an edge that happens
  // with enable low is consumed and never counted later.
  assign inc    = enable & ev & ((mode == CNT_LEVEL) | ~ev_q);
  assign at_max = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_q       <= 1'b0;
      cnt        <= '0;
      ovf        <= 1'b0;
      shadow_cnt <= '0;
      shadow_ovf <= 1'b0;
    end else begin
      ev_q <= ev;
      if (clear) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (inc) begin
        if (at_max) begin
          ovf <= 1'b1;
          cnt <= SATURATE ? cnt : '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      // Shadow takes the pre-edge values: excludes this cycle's increment
      // and precedes a simultaneous clear.
      if (snap) begin
        shadow_cnt <= cnt;
        shadow_ovf <= ovf;
      end
    end
  end

endmodule

// File: rtl/event_counter_bank.sv
// event_counter_bank: NUM_CH-channel event profiler with atomic snapshot.
//   clk, rst        : clock, asynchronous active-high reset
//   enable, clear   : global count enable / synchronous clear
//   ev_i, mode_i    : per-channel raw events and modes (0 LEVEL, 1 EDGE)
//   ovf_o           : live sticky overflow flags
//   bus             : snapshot handshake and registered shadow read port
module event_counter_bank
  import profiler_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int CNT_W    = PROF_CNT_W,
  parameter bit SATURATE = 1'b1,
  parameter int AW       = prof_aw(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ev_i,
  input  logic [NUM_CH-1:0] mode_i,
  output logic [NUM_CH-1:0] ovf_o,
  event_counter_bank_if.slave bus
);

  logic [CNT_W-1:0]  shadow_cnt [NUM_CH];
  logic [NUM_CH-1:0] shadow_ovf;
  // Live counts are only ever observed through the shadow bank.
  logic [CNT_W-1:0]  cnt_unused [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      event_counter_channel #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clear      (clear),
        .ev         (ev_i[gi]),
        .mode       (cnt_mode_t'(mode_i[gi])),
        .snap       (bus.snap_req),
        .cnt        (cnt_unused[gi]),
        .ovf        (ovf_o[gi]),
        .shadow_cnt (shadow_cnt[gi]),
        .shadow_ovf (shadow_ovf[gi])
      );
    end
  endgenerate

  logic addr_ok;
  assign addr_ok = 32'(bus.rd_addr) < 32'(NUM_CH);

  // Read samples the shadow before this edge's capture, so a read issued
  // together with snap_req returns the previous snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.snap_done <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_ovf    <= 1'b0;
    end else begin
      bus.snap_done <= bus.snap_req;
      bus.rd_valid  <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data <= addr_ok ? shadow_cnt[bus.rd_addr] : '0;
        bus.rd_ovf  <= addr_ok ? shadow_ovf[bus.rd_addr] : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_event_counter_bank.sv
// Two banks share one stimulus stream: an 8-channel saturating bank and a
// 6-channel wrapping bank (6 channels leaves addresses 6,7 out of range).
module tb_event_counter_bank;
  import profiler_pkg::*;

  localparam int CW   = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       enable = 1'b0, clear = 1'b0, snap_req = 1'b0, rd_en = 1'b0;
  logic [2:0] rd_addr = 3'd0;
  logic [7:0] ev = 8'h00, mode = 8'h00;
  logic [7:0] ovf_s;
  logic [5:0] ovf_w;

  event_counter_bank_if #(.NUM_CH(8), .CNT_W(CW)) bus_s ();
  event_counter_bank_if #(.NUM_CH(6), .CNT_W(CW)) bus_w ();

  assign bus_s.snap_req = snap_req;
  assign bus_s.rd_en    = rd_en;
  assign bus_s.rd_addr  = rd_addr;
  assign bus_w.snap_req = snap_req;
  assign bus_w.rd_en    = rd_en;
  assign bus_w.rd_addr  = rd_addr;

  event_counter_bank #(.NUM_CH(8), .CNT_W(CW), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .ev_i(ev), .mode_i(mode), .ovf_o(ovf_s), .bus(bus_s.slave)
  );

  event_counter_bank #(.NUM_CH(6), .CNT_W(CW), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .ev_i(ev[5:0]), .mode_i(mode[5:0]), .ovf_o(ovf_w), .bus(bus_w.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int d0; bit o0;
    int d1; bit o1;
  } rd_exp_t;

  rd_exp_t rdq[$];
  int  nch [2] = '{8, 6};
  bit  satv[2] = '{1'b1, 1'b0};
  int  m_cnt [2][8];
  bit  m_ovf [2][8];
  int  m_sh  [2][8];
  bit  m_sho [2][8];
  bit  m_prev[2][8];
  bit  exp_snap;
  bit  inc_b;
  int  nxt;
  rd_exp_t e_push, e_pop;
  logic [7:0] eo_s;
  logic [5:0] eo_w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 8; c++) begin
          m_cnt[d][c] = 0; m_ovf[d][c] = 0; m_sh[d][c] = 0;
          m_sho[d][c] = 0; m_prev[d][c] = 0;
        end
      exp_snap = 1'b0;
      rdq.delete();
    end else begin
      if (rd_en) begin
        e_push.d0 = m_sh[0][rd_addr];
        e_push.o0 = m_sho[0][rd_addr];
        e_push.d1 = (int'(rd_addr) < nch[1]) ? m_sh[1][rd_addr] : 0;
        e_push.o1 = (int'(rd_addr) < nch[1]) ? m_sho[1][rd_addr] : 1'b0;
        rdq.push_back(e_push);
      end
      exp_snap = snap_req;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < nch[d]; c++) begin
          inc_b = enable && ev[c] && (!mode[c] || !m_prev[d][c]);
          m_prev[d][c] = ev[c];
          if (snap_req) begin
            m_sh[d][c]  = m_cnt[d][c];
            m_sho[d][c] = m_ovf[d][c];
          end
          if (clear) begin
            m_cnt[d][c] = 0;
            m_ovf[d][c] = 0;
          end else if (inc_b) begin
            nxt = m_cnt[d][c] + 1;
            if (nxt > MAXV) begin
              m_ovf[d][c] = 1;
              nxt = satv[d] ? MAXV : nxt % (MAXV + 1);
            end
            m_cnt[d][c] = nxt;
          end
        end
    end
  end

  // Monitor: mid-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    for (int c = 0; c < 8; c++) eo_s[c] = m_ovf[0][c];
    for (int c = 0; c < 6; c++) eo_w[c] = m_ovf[1][c];
    chk("ovf_o_s", longint'(ovf_s), longint'(eo_s));
    chk("ovf_o_w", longint'(ovf_w), longint'(eo_w));
    chk("snap_done_s", longint'(bus_s.snap_done), longint'(exp_snap));
    chk("snap_done_w", longint'(bus_w.snap_done), longint'(exp_snap));
    if (rdq.size() > 0) begin
      e_pop = rdq.pop_front();
      chk("rd_valid_s", longint'(bus_s.rd_valid), 1);
      chk("rd_valid_w", longint'(bus_w.rd_valid), 1);
      chk("rd_data_s", longint'(bus_s.rd_data), longint'(e_pop.d0));
      chk("rd_ovf_s", longint'(bus_s.rd_ovf), longint'(e_pop.o0));
      chk("rd_data_w", longint'(bus_w.rd_data), longint'(e_pop.d1));
      chk("rd_ovf_w", longint'(bus_w.rd_ovf), longint'(e_pop.o1));
    end else begin
      chk("rd_idle_s", longint'(bus_s.rd_valid), 0);
      chk("rd_idle_w", longint'(bus_w.rd_valid), 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid_s"}, longint'(bus_s.rd_valid), 0);
    chk({tag, "_data_s"}, longint'(bus_s.rd_data), 0);
    chk({tag, "_rovf_s"}, longint'(bus_s.rd_ovf), 0);
    chk({tag, "_snap_s"}, longint'(bus_s.snap_done), 0);
    chk({tag, "_ovf_s"}, longint'(ovf_s), 0);
    chk({tag, "_valid_w"}, longint'(bus_w.rd_valid), 0);
    chk({tag, "_data_w"}, longint'(bus_w.rd_data), 0);
    chk({tag, "_ovf_w"}, longint'(ovf_w), 0);
  endtask

  task automatic snap();
    snap_req = 1'b1; step(1); snap_req = 1'b0;
  endtask

  // Read one channel (optionally with snap_req at the same edge) and check
  // the response against fixed values; a negative value skips that check.
  task automatic rd(input logic [2:0] a, input bit sn, input int es, input int eos,
                    input int ew, input int eow);
    rd_en = 1'b1; rd_addr = a; snap_req = sn;
    @(posedge clk); #1;
    rd_en = 1'b0; snap_req = 1'b0;
    if (es >= 0) begin
      chk("dir_valid_s", longint'(bus_s.rd_valid), 1);
      chk("dir_data_s", longint'(bus_s.rd_data), longint'(es));
      chk("dir_ovf_s", longint'(bus_s.rd_ovf), longint'(eos));
    end
    if (ew >= 0) begin
      chk("dir_valid_w", longint'(bus_w.rd_valid), 1);
      chk("dir_data_w", longint'(bus_w.rd_data), longint'(ew));
      chk("dir_ovf_w", longint'(bus_w.rd_ovf), longint'(eow));
    end
    @(negedge clk);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      enable   = ($urandom_range(0, 7) != 0);
      clear    = ($urandom_range(0, 599) == 0);
      ev       = 8'($urandom | $urandom);
      mode     = 8'($urandom);
      snap_req = ($urandom_range(0, 5) == 0);
      rd_en    = $urandom_range(0, 1) != 0;
      rd_addr  = 3'($urandom);
      step(1);
    end
    enable = 1'b0; clear = 1'b0; snap_req = 1'b0; rd_en = 1'b0; ev = 8'h00;
  endtask

  logic [6:0] pat;

  initial begin
    #2;
    chk_zero("reset");
    step(2);
    rst = 1'b0;

    // LEVEL: ch0 high for 5 cycles
    enable = 1'b1; ev = 8'h01; step(5);
    ev = 8'h00; snap();
    rd(3'd0, 1'b0, 5, 0, 5, 0);

    // EDGE: ch1 pattern 0110110 then high x4, then disabled edge
    mode = 8'h02;
    pat  = 7'b0110110;
    for (int i = 6; i >= 0; i--) begin
      ev[1] = pat[i]; step(1);
    end
    ev[1] = 1'b1; step(4);
    ev[1] = 1'b0; step(1);
    enable = 1'b0; ev[1] = 1'b1; step(1);
    enable = 1'b1; step(3);
    ev = 8'h00; snap();
    rd(3'd1, 1'b0, 3, 0, 3, 0);

    // Saturate / wrap: ch2 LEVEL for 260 cycles
    mode = 8'h00; ev = 8'h04; step(260);
    ev = 8'h00; step(1);
    chk("sat_ovf_s", longint'(ovf_s[2]), 1);
    chk("wrap_ovf_w", longint'(ovf_w[2]), 1);
    snap();
    rd(3'd2, 1'b0, 255, 1, 4, 1);
    clear = 1'b1; step(1); clear = 1'b0;
    chk("clr_ovf_s", longint'(ovf_s), 0);
    chk("clr_ovf_w", longint'(ovf_w), 0);
    snap();
    rd(3'd2, 1'b0, 0, 0, 0, 0);

    // Atomic snapshot with all channels high; read alongside snap sees old
    ev = 8'hFF; step(10);
    rd(3'd3, 1'b1, 0, 0, 0, 0);
    rd(3'd3, 1'b0, 10, 0, 10, 0);
    rd(3'd5, 1'b0, 10, 0, 10, 0);

    // clear + snap + event together: shadow pre-clear, event lost
    clear = 1'b1; snap_req = 1'b1; step(1);
    clear = 1'b0; snap_req = 1'b0; ev = 8'h00;
    rd(3'd0, 1'b0, 13, 0, 13, 0);
    snap();
    rd(3'd0, 1'b0, 0, 0, 0, 0);

    // Out-of-range reads on the 6-channel bank
    rd(3'd6, 1'b0, 0, 0, 0, 0);
    rd(3'd7, 1'b0, 0, 0, 0, 0);

    // Random traffic
    rand_cycles(1500);

    // Asynchronous reset mid-operation, checked before any clock edge
    enable = 1'b1; ev = 8'hFF; rd_en = 1'b1; snap_req = 1'b1; rd_addr = 3'd1;
    step(3);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    rd_en = 1'b0; snap_req = 1'b0;
    step(2);
    rst = 1'b0;
    rand_cycles(300);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_counter_bank.md
# event_counter_bank

Parametrised multi-channel event profiler. It counts per-channel events in either level or rising-edge mode, with saturating or wrapping counters and sticky overflow flags. An atomic snapshot copies all live counters into a shadow bank at once, and software reads the shadow bank through a registered read port. It sits beside the core and its cache profilers, taking raw event strobes (icache/dcache request, hit, miss, stall, …), and replaces per-signal hand-written counters.

## Interface
Parameters:
- NUM_CH, 8, number of event channels (1–32)
- CNT_W, 32, counter width in bits (8–64)
- SATURATE, 1, 1 = counter sticks at all-ones; 0 = counter wraps to 0
- AW, $clog2(NUM_CH) (min 1), read address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  count enable; when low, live counters hold their value
- clear  in  1  synchronous clear of all live counters and ovf flags
- ev_i  in  NUM_CH  raw event inputs
- mode_i  in  NUM_CH  per-channel mode: 0 = LEVEL (count every high cycle), 1 = EDGE (count 0→1 transitions)
- snap_req  in  1  capture all live counters and ovf flags into the shadow bank
- snap_done  out  1  one-cycle pulse, cycle after capture
- rd_en  in  1  read request
- rd_addr  in  AW  channel index to read
- rd_valid  out  1  read data valid, one-cycle pulse
- rd_data  out  CNT_W  shadow counter value
- rd_ovf  out  1  shadow overflow flag
- ovf_o  out  NUM_CH  live sticky overflow flags

## Operation
- Per channel, the increment condition `inc` is:
  - LEVEL mode: `enable & ev_i[c]`
  - EDGE mode: `enable & ev_i[c] & ~ev_q[c]`
- ev_q[c] is registered every cycle regardless of enable. An edge that occurs while disabled is therefore never counted later.
- ev_q resets to 0, so an input that is high in the first cycle after reset counts as an edge.
- Increment at count = 2^CNT_W−1:
  - SATURATE=1: count holds at all-ones and ovf is set.
  - SATURATE=0: count becomes 0 and ovf is set.
  - ovf stays set until clear or rst.
- clear has priority over inc. At that edge count←0 and ovf←0; an event in the same cycle is lost.
- Snapshot: on a snap_req edge, shadow_cnt[c]←live count[c] and shadow_ovf[c]←ovf[c]. Values are the pre-edge register values, so they exclude that cycle's increment and precede any clear.
- Live counters keep running through a snapshot.
- snap_req while disabled is still honoured.
- Read: rd_en with rd_addr<NUM_CH returns the shadow entry. rd_addr≥NUM_CH returns rd_data=0 and rd_ovf=0, with rd_valid still pulsing.
- mode_i may change at any time and takes effect for that cycle's inc evaluation.

## Timing
- Reset values: all counters, shadow registers, ovf, ev_q, snap_done, rd_valid, rd_data and rd_ovf are 0.
- Count latency: an event in cycle t is visible in the live count (and ovf_o) after the edge ending cycle t, i.e. in cycle t+1.
- snap_req sampled at edge e: shadow is updated at e and snap_done is high for the cycle after e.
- Back-to-back snap_req produces one capture and one snap_done per cycle.
- rd_en sampled at edge e: rd_valid/rd_data/rd_ovf are registered at e and valid for one cycle.
- rd_en and snap_req at the same edge: the read returns the old shadow value.
- rst mid-operation: all state clears immediately, asynchronously. Outputs are 0 until the first post-reset events.
- Throughput: one increment per channel per cycle; one read per cycle.

## Structure
- Package profiler_pkg holds:
  - typedef enum logic {CNT_LEVEL=1'b0, CNT_EDGE=1'b1} cnt_mode_t
  - shared width localparams reused by the cache profilers
- Sub-module event_counter_channel (parameters CNT_W, SATURATE) holds ev_q, the counter, ovf, and the shadow pair for one channel.
  - Its ports are enable, clear, ev, mode, snap, cnt, ovf, shadow_cnt and shadow_ovf.
  - The top level instantiates NUM_CH copies via generate and adds the snap_done register and the read mux/register.

## Test plan
- LEVEL counting: ch0 LEVEL, ev high for 5 cycles, enable=1, then snap_req and read addr 0 → rd_data=5, rd_ovf=0, rd_valid one cycle after rd_en.
- EDGE counting: ch1 EDGE, ev pattern 0110110 then high for 4 cycles → count=3. Raise ev while enable=0 and hold it high after re-enable → count unchanged.
- SATURATE=1, CNT_W=8: 260 LEVEL cycles → count=255, ovf_o[c]=1. SATURATE=0 with the same stimulus → count=4, ovf=1. Then clear → count=0, ovf=0.
- Snapshot atomicity: all 8 channels LEVEL high continuously with snap_req at cycle 10 → every shadow equals the live count at the start of cycle 10. snap_done pulses in cycle 11. A read issued with the same snap_req returns the previous shadow.
- Priority: clear and ev in the same cycle → count=0 next cycle. snap_req and clear in the same cycle → shadow holds the pre-clear value and live count is 0.
- Reset/bounds: assert rst mid-count → all outputs 0 immediately, no clock needed. Read rd_addr=NUM_CH → rd_data=0, rd_valid=1.
